// File: rtl/stack_cpu_pkg.sv
// stack_cpu_pkg: shared word/depth constants for the register bank and operand
// stack, plus the per-cycle operation encoding used by the stack control logic.
package stack_cpu_pkg;

    localparam int WORD_W      = 16;
    localparam int STACK_DEPTH = 8;

    typedef enum logic [2:0] {
        OP_IDLE,
        OP_PUSH,
        OP_POP,
        OP_SWAP,
        OP_DROP
    } stack_op_e;

    // A pop against a non-empty stack wins first; a push paired with it becomes
    // an in-place overwrite of TOS, which is why it stays legal when full.
    function automatic stack_op_e classify(
        input logic push,
        input logic pop,
        input logic full,
        input logic empty
    );
        if (pop && !empty)
            return push ? OP_SWAP : OP_POP;
        if (push)
            return full ? OP_DROP : OP_PUSH;
        return OP_IDLE;
    endfunction

endpackage

// File: rtl/opstack_mem.sv
// opstack_mem: DEPTH x WIDTH storage, one synchronous write port and one
// asynchronous read port; contents are not reset.
module opstack_mem #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] waddr,
    input  logic [WIDTH-1:0]         wdata,
    input  logic [$clog2(DEPTH)-1:0] raddr,
    output logic [WIDTH-1:0]         rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk)
        if (we)
            mem[waddr] <= wdata;

    assign rdata = mem[raddr];

endmodule

// File: rtl/operand_stack.sv
// operand_stack: LIFO operand stack with registered pop output and err flag.
// Define OPERAND_STACK_STICKY_ERR_EN to make err latch until reset.
module operand_stack
    import stack_cpu_pkg::*;
#(
    parameter int WIDTH = WORD_W,
    parameter int DEPTH = STACK_DEPTH
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   push_valid,
    input  logic [WIDTH-1:0]       push_data,
    output logic                   push_ready,
    input  logic                   pop_req,
    output logic                   pop_valid,
    output logic [WIDTH-1:0]       pop_data,
    output logic [WIDTH-1:0]       tos,
    output logic [$clog2(DEPTH):0] depth,
    output logic                   full,
    output logic                   empty,
    output logic                   err
);

    localparam int AW = $clog2(DEPTH);
    localparam int DW = AW + 1;

    stack_op_e        op;
    logic             wr_en;
    logic             fault;
    logic [AW-1:0]    wr_addr;
    logic [AW-1:0]    top_addr;
    logic [WIDTH-1:0] top_word;

    assign full       = depth == DW'(DEPTH);
    assign empty      = depth == '0;
    assign push_ready = !full || pop_req;
    assign top_addr   = AW'(depth - DW'(1));
    assign tos        = empty ? '0 : top_word;

    always_comb begin
        op      = classify(push_valid, pop_req, full, empty);
        fault   = (push_valid && !push_ready) || (pop_req && empty);
        // A cycle under reset must not touch storage either.
        wr_en   = reset && (op == OP_PUSH || op == OP_SWAP);
        wr_addr = op == OP_SWAP ? top_addr : AW'(depth);
    end

    opstack_mem #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_mem (
        .clk  (clk),
        .we   (wr_en),
        .waddr(wr_addr),
        .wdata(push_data),
        .raddr(top_addr),
        .rdata(top_word)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            depth     <= '0;
            pop_valid <= 1'b0;
            pop_data  <= '0;
            err       <= 1'b0;
        end else begin
            depth     <= op == OP_PUSH ? depth + DW'(1) :
                         op == OP_POP  ? depth - DW'(1) : depth;
            pop_valid <= op == OP_POP || op == OP_SWAP;
            if (op == OP_POP || op == OP_SWAP)
                pop_data <= top_word;
`ifdef OPERAND_STACK_STICKY_ERR_EN
            err       <= err || fault;
`else
            err       <= fault;
`endif
        end
    end

endmodule

// File: tb/tb_operand_stack.sv
// tb_operand_stack: directed self-checking bench for operand_stack.
module tb_operand_stack;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        push_valid = 1'b0;
    logic [15:0] push_data = '0;
    logic        push_ready;
    logic        pop_req = 1'b0;
    logic        pop_valid;
    logic [15:0] pop_data;
    logic [15:0] tos;
    logic [3:0]  depth;
    logic        full;
    logic        empty;
    logic        err;

    int total = 0;
    int bad = 0;

`ifdef OPERAND_STACK_STICKY_ERR_EN
    localparam logic STICKY = 1'b1;
`else
    localparam logic STICKY = 1'b0;
`endif

    operand_stack dut (
        .clk       (clk),
        .reset     (reset),
        .push_valid(push_valid),
        .push_data (push_data),
        .push_ready(push_ready),
        .pop_req   (pop_req),
        .pop_valid (pop_valid),
        .pop_data  (pop_data),
        .tos       (tos),
        .depth     (depth),
        .full      (full),
        .empty     (empty),
        .err       (err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Drive one cycle of stimulus, then return at the falling edge with inputs idle.
    task automatic cyc(input logic pv, input logic [15:0] pd, input logic pr);
        push_valid = pv;
        push_data  = pd;
        pop_req    = pr;
        @(posedge clk);
        @(negedge clk);
        push_valid = 1'b0;
        pop_req    = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
    endtask

    initial begin
        @(negedge clk);
        do_reset();
        check("rst_depth", depth, 0);
        check("rst_empty", empty, 1);
        check("rst_full", full, 0);
        check("rst_pop_valid", pop_valid, 0);
        check("rst_pop_data", pop_data, 0);
        check("rst_err", err, 0);
        check("rst_tos", tos, 0);

        cyc(1, 16'h1111, 0);
        cyc(1, 16'h2222, 0);
        cyc(1, 16'h3333, 0);
        check("p3_depth", depth, 3);
        check("p3_tos", tos, 16'h3333);
        check("p3_empty", empty, 0);
        check("p3_pop_valid", pop_valid, 0);

        cyc(0, 0, 1);
        check("pop1_valid", pop_valid, 1);
        check("pop1_data", pop_data, 16'h3333);
        check("pop1_depth", depth, 2);
        check("pop1_tos", tos, 16'h2222);
        cyc(0, 0, 1);
        check("pop2_data", pop_data, 16'h2222);
        check("pop2_depth", depth, 1);
        check("pop2_tos", tos, 16'h1111);
        cyc(0, 0, 0);
        check("idle_valid", pop_valid, 0);
        check("idle_hold", pop_data, 16'h2222);

        do_reset();
        for (int i = 0; i < 8; i++)
            cyc(1, 16'h1000 + 16'(i), 0);
        check("fill_depth", depth, 8);
        check("fill_full", full, 1);
        check("fill_tos", tos, 16'h1007);
        push_valid = 1'b1;
        push_data  = 16'hDEAD;
        #1;
        check("ovf_ready", push_ready, 0);
        cyc(1, 16'hDEAD, 0);
        check("ovf_err", err, 1);
        check("ovf_depth", depth, 8);
        check("ovf_tos", tos, 16'h1007);
        check("ovf_pop_valid", pop_valid, 0);
        cyc(0, 0, 0);
        check("ovf_err_after", err, STICKY);

        do_reset();
        for (int i = 0; i < 8; i++)
            cyc(1, 16'h1000 + 16'(i), 0);
        push_valid = 1'b1;
        pop_req    = 1'b1;
        #1;
        check("swap_ready", push_ready, 1);
        cyc(1, 16'hBEEF, 1);
        check("swap_valid", pop_valid, 1);
        check("swap_data", pop_data, 16'h1007);
        check("swap_tos", tos, 16'hBEEF);
        check("swap_depth", depth, 8);
        check("swap_err", err, 0);

        cyc(0, 0, 1);
        check("drain_top", pop_data, 16'hBEEF);
        for (int i = 6; i >= 0; i--) begin
            cyc(0, 0, 1);
            check($sformatf("drain_%0d", i), pop_data, 16'h1000 + 16'(i));
        end
        check("drain_depth", depth, 0);
        check("drain_empty", empty, 1);
        check("drain_tos", tos, 0);

        cyc(0, 0, 1);
        check("unf_valid", pop_valid, 0);
        check("unf_err", err, 1);
        check("unf_depth", depth, 0);
        check("unf_hold", pop_data, 16'h1000);
        cyc(0, 0, 0);
        check("unf_err_after", err, STICKY);

        cyc(1, 16'h4444, 1);
        check("epp_depth", depth, 1);
        check("epp_tos", tos, 16'h4444);
        check("epp_valid", pop_valid, 0);
        check("epp_err", err, 1);

        do_reset();
        check("clr_err", err, 0);
        for (int i = 0; i < 5; i++)
            cyc(1, 16'h5000 + 16'(i), 0);
        check("d5_depth", depth, 5);
        cyc(0, 0, 1);
        check("d5_pop_valid", pop_valid, 1);
        reset = 1'b0;
        cyc(1, 16'h7777, 1);
        reset = 1'b1;
        check("rmid_depth", depth, 0);
        check("rmid_empty", empty, 1);
        check("rmid_pop_valid", pop_valid, 0);
        check("rmid_pop_data", pop_data, 0);
        check("rmid_tos", tos, 0);
        cyc(1, 16'h8888, 0);
        check("post_tos", tos, 16'h8888);
        check("post_depth", depth, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
